// File: rtl/c1541_track_sched.sv
// ============================================================================
// c1541_track_sched : schedules whole-track SD reads/write-backs for a 1541 drive
// Revision 1.0
// ============================================================================
`default_nettype none

module c1541_track_sched #(
    parameter int MAX_TRACK = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  track,
    input  logic        save_track,
    input  logic        change,
    output logic [31:0] sd_lba,
    output logic [5:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_ACK = 3'd2,
        WR_REQ = 3'd3,
        WR_ACK = 3'd4
    } state_t;

    localparam logic [6:0] c_max_track = 7'(MAX_TRACK);

    state_t      r_state;
    logic [6:0]  r_t;
    logic        r_save_q;
    logic        r_change_q;
    logic        r_valid;
    logic        r_wr_pend;
    logic        r_discard;
    logic [6:0]  r_res_t;
    logic [9:0]  r_res_base;
    logic [5:0]  r_res_spt;

    logic [6:0]  w_t_raw;
    logic [9:0]  w_t10;
    logic [9:0]  w_base;
    logic [5:0]  w_spt;
    logic        w_save_edge;
    logic        w_change_rise;
    logic        w_wb_cond;
    logic        w_ld_cond;

    assign w_t_raw       = {1'b0, track[6:1]} + 7'd1;
    assign w_save_edge   = save_track ^ r_save_q;
    assign w_change_rise = change & ~r_change_q;
    assign w_wb_cond     = r_wr_pend & r_valid;
    assign w_ld_cond     = ~r_valid | (r_t != r_res_t);
    assign busy          = (r_state != IDLE) | w_wb_cond | w_ld_cond;

    // Left unreset so they follow their inputs while reset is held; edges are
    // therefore measured against the input values present at reset release.
    always_ff @(posedge clk) begin
        r_t        <= (w_t_raw > c_max_track) ? c_max_track : w_t_raw;
        r_save_q   <= save_track;
        r_change_q <= change;
    end

    // Zone layout: 17x21, 7x19, 6x18, then 17 sectors per track
    always_comb begin
        w_t10 = {3'd0, r_t};
        if (r_t <= 7'd17) begin
            w_spt  = 6'd21;
            w_base = (w_t10 - 10'd1) * 10'd21;
        end else if (r_t <= 7'd24) begin
            w_spt  = 6'd19;
            w_base = 10'd357 + (w_t10 - 10'd18) * 10'd19;
        end else if (r_t <= 7'd30) begin
            w_spt  = 6'd18;
            w_base = 10'd490 + (w_t10 - 10'd25) * 10'd18;
        end else begin
            w_spt  = 6'd17;
            w_base = 10'd598 + (w_t10 - 10'd31) * 10'd17;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_lba     <= 32'd0;
            sd_blk_cnt <= 6'd0;
            r_valid    <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_discard  <= 1'b0;
            r_res_t    <= 7'd0;
            r_res_base <= 10'd0;
            r_res_spt  <= 6'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wb_cond) begin
                        r_state    <= WR_REQ;
                        sd_wr      <= 1'b1;
                        sd_lba     <= {22'd0, r_res_base};
                        sd_blk_cnt <= r_res_spt - 6'd1;
                        r_wr_pend  <= 1'b0;
                    end else begin
                        // Nothing resident to write back: drop the request
                        if (!r_valid)
                            r_wr_pend <= 1'b0;
                        if (w_ld_cond) begin
                            r_state    <= RD_REQ;
                            sd_rd      <= 1'b1;
                            sd_lba     <= {22'd0, w_base};
                            sd_blk_cnt <= w_spt - 6'd1;
                            r_res_t    <= r_t;
                            r_res_base <= w_base;
                            r_res_spt  <= w_spt;
                            r_discard  <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (sd_ack) begin
                        sd_rd   <= 1'b0;
                        r_state <= RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (!sd_ack) begin
                        r_state <= IDLE;
                        r_valid <= ~r_discard;
                    end
                end
                WR_REQ: begin
                    if (sd_ack) begin
                        sd_wr   <= 1'b0;
                        r_state <= WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (!sd_ack)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_save_edge)
                r_wr_pend <= 1'b1;

            // A new disk invalidates whatever is resident or still arriving
            if (w_change_rise) begin
                r_valid   <= 1'b0;
                r_wr_pend <= 1'b0;
                r_discard <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/c1541_track_sched.md
C1541_TRACK_SCHED -- requirements
Module: c1541_track_sched

Interface
REQ-001 SHALL have parameter MAX_TRACK, default 40, meaning the highest loadable 1-based track number; higher requests are clamped to it.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port track  input  7  current half-track from the stepper, range 0..84.
REQ-005 SHALL have port save_track  input  1  toggle; every edge (0->1 or 1->0) requests a write-back of the resident track.
REQ-006 SHALL have port change  input  1  image-mounted level; its rising edge marks a new disk.
REQ-007 SHALL have port sd_lba  output  32  start sector of the transfer, in 256-byte units.
REQ-008 SHALL have port sd_blk_cnt  output  6  number of sectors in the transfer minus one.
REQ-009 SHALL have port sd_rd  output  1  read request.
REQ-010 SHALL have port sd_wr  output  1  write request.
REQ-011 SHALL have port sd_ack  input  1  host acknowledge; high for the whole transfer.
REQ-012 SHALL have port busy  output  1  high while any transfer is pending or in flight.

Function
REQ-013 SHALL compute T = min(track[6:1]+1, MAX_TRACK), registered one cycle after track.
REQ-014 SHALL compute sectors per track (SPT) from T: 21 for 1..17; 19 for 18..24; 18 for 25..30; 17 for 31 and above.
REQ-015 SHALL compute base sector from T: (T-1)*21 for T<=17; 357+(T-18)*19 for T<=24; 490+(T-25)*18 for T<=30; 598+(T-31)*17 otherwise. Upper 22 bits of sd_lba are 0.
REQ-016 SHALL hold a resident record: valid flag, resident T, base and SPT, all latched when a read is issued.
REQ-017 SHALL use FSM states IDLE, RD_REQ, RD_ACK, WR_REQ, WR_ACK.
REQ-018 SHALL set a write-pending flag on every save_track edge, detected against a registered copy. The flag is cleared on entry to WR_REQ.
REQ-019 In IDLE, priority 1 is the write-back: if write-pending and valid, go to WR_REQ with sd_lba and sd_blk_cnt from the resident record.
REQ-020 In IDLE, priority 2 is the load: if not valid, or T differs from resident T, go to RD_REQ with sd_lba = base(T) and sd_blk_cnt = SPT(T)-1, and latch the resident record.
REQ-021 In IDLE, if write-pending is set and valid is clear, the flag SHALL be dropped without any transfer.
REQ-022 In RD_REQ/WR_REQ, sd_rd/sd_wr SHALL stay high until the first cycle sd_ack is sampled high, then drop, and the FSM moves to RD_ACK/WR_ACK.
REQ-023 In RD_ACK/WR_ACK, the FSM SHALL wait for sd_ack low. Completing RD_ACK sets valid. Both return to IDLE.
REQ-024 sd_rd and sd_wr SHALL never be high together. sd_lba and sd_blk_cnt SHALL be stable from the request until ack falls.
REQ-025 busy SHALL be high when the state is not IDLE, or when a write-back or load condition is true in IDLE; low otherwise.
REQ-026 On a rising edge of change, valid and write-pending SHALL be cleared. A transfer already in flight completes its handshake, then a fresh load of T follows.
REQ-027 A save_track edge that arrives during a transfer SHALL be kept pending and serviced after the current transfer, before any load.
REQ-028 If T changes during a read, the read SHALL complete, valid is set for the old T, and the new T is loaded next.
REQ-029 The minimum latency from an IDLE condition to sd_rd/sd_wr high SHALL be 1 clk.

Reset
REQ-030 Asynchronous reset SHALL force: state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, valid=0, write-pending=0, save_track and change edge registers loaded from their current inputs. busy becomes 1 on the first cycle after reset release, because a load is pending.
REQ-031 Reset asserted mid-transfer SHALL abort immediately without waiting for sd_ack. After release a fresh load is issued.

Verification
REQ-032 Reset release with track=36 (T=19) -> sd_rd=1, sd_lba=376, sd_blk_cnt=18. Ack pulse -> sd_rd low; busy low after ack falls.
REQ-033 Resident T=19, track stepped to 38 together with a save_track toggle -> sd_wr with lba 376/cnt 18 first, then sd_rd with lba 395/cnt 18.
REQ-034 track=84 -> T clamped to 40, sd_lba=751, sd_blk_cnt=16. track=0 -> sd_lba=0, sd_blk_cnt=20.
REQ-035 change rises during RD_ACK -> handshake completes, then the same T is re-read once. A save_track toggle issued before the change produces no write.
REQ-036 Two save_track toggles during a read -> exactly one write after the read, then idle.
REQ-037 Hold sd_ack low for 1000 cycles after a request -> sd_rd remains high, lba/cnt stable, busy high throughout.
